// File: rtl/intra4x4_mode_decision_if.sv
// Request/result bundle between the 4x4 luma extractor, the mode-decision stage and the residual stage.
interface intra4x4_mode_decision_if #(parameter int SAD_W = 12);
  logic              start;
  logic [15:0][7:0]  mb;
  logic [7:0][7:0]   toppixels;
  logic [4:0][7:0]   leftpixels;
  logic              top_avail;
  logic              left_avail;
  logic              busy;
  logic              done;
  logic [1:0]        best_mode;
  logic [SAD_W-1:0]  best_sad;
  logic [15:0][7:0]  pred;

  modport master (
    output start, mb, toppixels, leftpixels, top_avail, left_avail,
    input  busy, done, best_mode, best_sad, pred
  );

  modport slave (
    input  start, mb, toppixels, leftpixels, top_avail, left_avail,
    output busy, done, best_mode, best_sad, pred
  );
endinterface

// File: rtl/intra4x4_mode_decision.sv
// Luma 4x4 intra mode decision: scores V, H, DC and DDL by SAD, one mode per cycle, keeps the best.
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// EVAL  | mode counter m = 0..3, one candidate scored per cycle
// DONE  | one-cycle done pulse with the result
module intra4x4_mode_decision #(
  parameter int SAD_W = 12
) (
  input logic clk,
  input logic reset,
  intra4x4_mode_decision_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t            state;
  logic [1:0]        m;
  logic [15:0][7:0]  mb_q;
  logic [7:0][7:0]   t_q;
  logic [4:0][7:0]   l_q;
  logic              top_q;
  logic              left_q;
  logic              busy_q;
  logic              done_q;
  logic              best_valid;
  logic [1:0]        best_mode_q;
  logic [SAD_W-1:0]  best_sad_q;
  logic [15:0][7:0]  pred_q;

  logic [9:0]        sum_t;
  logic [9:0]        sum_l;
  logic [10:0]       sum_tl;
  logic [9:0]        half;
  logic [7:0]        dc;
  logic [9:0]        ddl_acc;
  logic [6:0][7:0]   ddl;
  logic [15:0][7:0]  pred_cur;
  logic [7:0]        ad;
  logic [SAD_W-1:0]  sad_cur;
  logic              cand;

  always_comb begin
    sum_t    = '0;
    sum_l    = '0;
    ddl_acc  = '0;
    ddl      = '0;
    pred_cur = '0;
    sad_cur  = '0;
    ad       = '0;
    for (int i = 0; i < 4; i++) begin
      sum_t = sum_t + {2'b00, t_q[i]};
      sum_l = sum_l + {2'b00, l_q[i+1]};
    end
    sum_tl = {1'b0, sum_t} + {1'b0, sum_l} + 11'd4;
    half   = (top_q ? sum_t : sum_l) + 10'd2;
    if (top_q && left_q)
      dc = sum_tl[10:3];
    else if (top_q || left_q)
      dc = half[9:2];
    else
      dc = 8'd128;

    for (int k = 0; k < 6; k++) begin
      ddl_acc = {2'b00, t_q[k]} + {1'b0, t_q[k+1], 1'b0} + {2'b00, t_q[k+2]} + 10'd2;
      ddl[k]  = ddl_acc[9:2];
    end
    // Last diagonal has no t[8]; t[7] is repeated instead.
    ddl_acc = {2'b00, t_q[6]} + {1'b0, t_q[7], 1'b0} + {2'b00, t_q[7]} + 10'd2;
    ddl[6]  = ddl_acc[9:2];

    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        case (m)
          2'd0:    pred_cur[y*4+x] = t_q[x];
          2'd1:    pred_cur[y*4+x] = l_q[y+1];
          2'd2:    pred_cur[y*4+x] = dc;
          default: pred_cur[y*4+x] = ddl[x+y];
        endcase
      end
    end

    for (int i = 0; i < 16; i++) begin
      ad      = (mb_q[i] > pred_cur[i]) ? (mb_q[i] - pred_cur[i]) : (pred_cur[i] - mb_q[i]);
      sad_cur = sad_cur + SAD_W'(ad);
    end

    cand = !(((m == 2'd0) || (m == 2'd3)) && !top_q) && !((m == 2'd1) && !left_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      m           <= '0;
      mb_q        <= '0;
      t_q         <= '0;
      l_q         <= '0;
      top_q       <= 1'b0;
      left_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_valid  <= 1'b0;
      best_mode_q <= '0;
      best_sad_q  <= '0;
      pred_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mb_q       <= bus.mb;
            t_q        <= bus.toppixels;
            l_q        <= bus.leftpixels;
            top_q      <= bus.top_avail;
            left_q     <= bus.left_avail;
            busy_q     <= 1'b1;
            m          <= '0;
            best_sad_q <= '1;
            best_valid <= 1'b0;
            state      <= EVAL;
          end
        end
        EVAL: begin
          // Strict compare keeps the lower mode number on ties.
          if (cand && (!best_valid || (sad_cur < best_sad_q))) begin
            best_mode_q <= m;
            best_sad_q  <= sad_cur;
            pred_q      <= pred_cur;
            best_valid  <= 1'b1;
          end
          m <= m + 2'd1;
          if (m == 2'd3) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.best_mode = best_mode_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.pred      = pred_q;

endmodule
